// File: rtl/kappa3_dbg_loader.sv
// kappa3_dbg_loader: turns framed host bytes into timed debug-port sequences for kappa3_light_core.
module kappa3_dbg_loader #(
  parameter int SETTLE_CYCLES = 2,
  parameter int RUN_PULSE = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic        running,
  input  logic [31:0] dbg_pc_out,
  input  logic [31:0] dbg_reg_out,
  input  logic [31:0] dbg_mem_out,
  output logic [31:0] dbg_in,
  output logic [31:0] dbg_mem_addr,
  output logic [4:0]  dbg_reg_addr,
  output logic        dbg_pc_ld,
  output logic        dbg_reg_ld,
  output logic        dbg_mem_read,
  output logic        dbg_mem_write,
  output logic        run
);
  typedef enum logic [2:0] {IDLE, ARG, WAIT_HALT, SETUP, STROBE, SETTLE, RUNP, RESP} state_t;
  localparam logic [2:0] OP_WPC = 3'd1, OP_WMEM = 3'd2, OP_RMEM = 3'd3, OP_WREG = 3'd4,
                         OP_RREG = 3'd5, OP_RUN = 3'd6, OP_RPC = 3'd7;
  state_t state, nxt, go;
  logic [2:0] op, opx;
  logic [3:0] cnt, nargs;
  logic [63:0] sh, sh_nx;
  logic [31:0] rbuf, src;
  logic [1:0] rcnt;
  logic [7:0] tcnt;
  logic acc, known, is_read, settle_done, run_done;
  logic pc_ld_d, reg_ld_d, mem_read_d, mem_write_d;
  assign in_ready = state == IDLE || state == ARG;
  assign acc = in_valid && in_ready;
  assign known = in_data[7:3] == 5'd0 && in_data[2:0] != 3'd0;
  assign sh_nx = acc ? {sh[55:0], in_data} : sh;
  assign settle_done = state == SETTLE && tcnt == 8'(SETTLE_CYCLES - 1);
  assign run_done = state == RUNP && tcnt == 8'(RUN_PULSE - 1);
  assign out_data = rbuf[31:24];
  always_ff @(posedge clock) state <= reset ? IDLE : nxt;
  // With running low the halt wait is skipped so SETUP lands the cycle after the last byte.
  always_comb begin
    opx = state == IDLE ? in_data[2:0] : op;
    nargs = in_data[2:0] == OP_WMEM ? 4'd8 : in_data[2:0] == OP_WREG ? 4'd5 :
            in_data[2:0] == OP_RREG ? 4'd1 :
            (in_data[2:0] == OP_RUN || in_data[2:0] == OP_RPC) ? 4'd0 : 4'd4;
    go = running ? WAIT_HALT : opx == OP_RUN ? RUNP : SETUP;
    nxt = state;
    case (state)
      IDLE:      if (acc) nxt = !known ? RESP : nargs == 4'd0 ? go : ARG;
      ARG:       if (acc && cnt == 4'd1) nxt = go;
      WAIT_HALT: if (!running) nxt = go;
      SETUP:     nxt = STROBE;
      STROBE:    nxt = SETTLE;
      SETTLE:    if (settle_done) nxt = RESP;
      RUNP:      if (run_done) nxt = RESP;
      RESP:      if (out_ready && rcnt == 2'd0) nxt = IDLE;
    endcase
  end
  always_comb begin
    pc_ld_d = nxt == STROBE && op == OP_WPC;
    reg_ld_d = nxt == STROBE && op == OP_WREG;
    mem_read_d = nxt == STROBE && op == OP_RMEM;
    mem_write_d = nxt == STROBE && op == OP_WMEM;
    is_read = op == OP_RMEM || op == OP_RREG || op == OP_RPC;
    src = op == OP_RMEM ? dbg_mem_out : op == OP_RREG ? dbg_reg_out : dbg_pc_out;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      op <= 3'd0;
      cnt <= 4'd0;
      sh <= 64'd0;
      rbuf <= 32'd0;
      rcnt <= 2'd0;
      tcnt <= 8'd0;
      dbg_in <= 32'd0;
      dbg_mem_addr <= 32'd0;
      dbg_reg_addr <= 5'd0;
      dbg_pc_ld <= 1'b0;
      dbg_reg_ld <= 1'b0;
      dbg_mem_read <= 1'b0;
      dbg_mem_write <= 1'b0;
      run <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      sh <= sh_nx;
      tcnt <= nxt == state ? tcnt + 8'd1 : 8'd0;
      if (state == IDLE && acc) begin
        op <= in_data[2:0];
        cnt <= nargs;
      end
      if (state == ARG && acc) cnt <= cnt - 4'd1;
      if (nxt == SETUP) begin
        if (opx == OP_WPC || opx == OP_WMEM || opx == OP_WREG) dbg_in <= sh_nx[31:0];
        if (opx == OP_WMEM) dbg_mem_addr <= sh_nx[63:32];
        if (opx == OP_RMEM) dbg_mem_addr <= sh_nx[31:0];
        if (opx == OP_WREG) dbg_reg_addr <= sh_nx[36:32];
        if (opx == OP_RREG) dbg_reg_addr <= sh_nx[4:0];
      end
      dbg_pc_ld <= pc_ld_d;
      dbg_reg_ld <= reg_ld_d;
      dbg_mem_read <= mem_read_d;
      dbg_mem_write <= mem_write_d;
      run <= nxt == RUNP;
      out_valid <= nxt == RESP;
      if (state == IDLE && acc && !known) begin
        rbuf <= {8'hEE, 24'd0};
        rcnt <= 2'd0;
      end else if (settle_done) begin
        rbuf <= is_read ? src : {8'hAA, 24'd0};
        rcnt <= is_read ? 2'd3 : 2'd0;
      end else if (run_done) begin
        rbuf <= {8'hAA, 24'd0};
        rcnt <= 2'd0;
      end else if (state == RESP && out_ready) begin
        rbuf <= rbuf << 8;
        rcnt <= rcnt - 2'd1;
      end
    end
  end
endmodule

// File: tb/tb_kappa3_dbg_loader.sv
// tb_kappa3_dbg_loader: directed commands with a response scoreboard and a small core model.
module tb_kappa3_dbg_loader;
  logic clock = 0, reset = 1;
  logic [7:0] in_data = 0, out_data;
  logic in_valid = 0, in_ready, out_valid, out_ready = 1, running = 0;
  logic [31:0] dbg_pc_out, dbg_reg_out, dbg_mem_out, dbg_in, dbg_mem_addr;
  logic [4:0] dbg_reg_addr;
  logic dbg_pc_ld, dbg_reg_ld, dbg_mem_read, dbg_mem_write, run;
  int checks = 0, failures = 0, cyc = 0, acc_cyc = 0, stb_cyc = 0, ov_cyc = 0, run_cyc = 0;
  int n_pc = 0, n_reg = 0, n_mr = 0, n_mw = 0, n_run = 0, n_pop = 0;
  logic [7:0] sb[$];
  logic [31:0] stb_in = 0, stb_pre = 0, stb_post = 0, prev_dbg_in = 0;
  logic prev_any = 0, prev_run = 0, prev_ov = 0, post_pend = 0;
  logic [31:0] mem[16], regs[32], pc = 0;

  kappa3_dbg_loader dut (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .running(running),
    .dbg_pc_out(dbg_pc_out), .dbg_reg_out(dbg_reg_out), .dbg_mem_out(dbg_mem_out),
    .dbg_in(dbg_in), .dbg_mem_addr(dbg_mem_addr), .dbg_reg_addr(dbg_reg_addr),
    .dbg_pc_ld(dbg_pc_ld), .dbg_reg_ld(dbg_reg_ld), .dbg_mem_read(dbg_mem_read),
    .dbg_mem_write(dbg_mem_write), .run(run)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Minimal core debug model: loads on strobes, combinational read-back.
  always @(posedge clock) begin
    if (dbg_pc_ld) pc <= dbg_in;
    if (dbg_reg_ld) regs[dbg_reg_addr] <= dbg_in;
    if (dbg_mem_write) mem[dbg_mem_addr[5:2]] <= dbg_in;
  end
  assign dbg_pc_out = pc;
  assign dbg_reg_out = regs[dbg_reg_addr];
  assign dbg_mem_out = mem[dbg_mem_addr[5:2]];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (out_valid && out_ready) begin
        n_pop++;
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_byte actual=%0h required=none", out_data);
        end else chk("resp_byte", {56'd0, out_data}, {56'd0, sb.pop_front()});
      end
      if (post_pend) begin
        stb_post = dbg_in;
        post_pend = 0;
      end
      if ((dbg_pc_ld | dbg_reg_ld | dbg_mem_read | dbg_mem_write) && !prev_any) begin
        stb_cyc = cyc;
        stb_pre = prev_dbg_in;
        stb_in = dbg_in;
        post_pend = 1;
      end
      if (run && !prev_run) run_cyc = cyc;
      if (out_valid && !prev_ov) ov_cyc = cyc;
      n_pc += int'(dbg_pc_ld);
      n_reg += int'(dbg_reg_ld);
      n_mr += int'(dbg_mem_read);
      n_mw += int'(dbg_mem_write);
      n_run += int'(run);
    end
    prev_any = dbg_pc_ld | dbg_reg_ld | dbg_mem_read | dbg_mem_write;
    prev_run = run;
    prev_ov = out_valid;
    prev_dbg_in = dbg_in;
  end

  task automatic send_byte(input logic [7:0] b);
    bit done = 0;
    @(posedge clock);
    #1;
    in_data = b;
    in_valid = 1;
    for (int i = 0; i < 200 && !done; i++) begin
      done = in_ready;
      @(posedge clock);
      #1;
    end
    acc_cyc = cyc - 1;
    in_valid = 0;
    if (!done) chk("send_timeout", 0, 1);
  endtask

  task automatic send4(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic expect4(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) sb.push_back(w[i*8 +: 8]);
  endtask

  task automatic wait_drain(input string name);
    bit done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clock);
      done = sb.size() == 0 && in_ready;
    end
    if (!done) chk(name, 0, 1);
  endtask

  initial begin
    int base, base2, r_acc, r_ov, pops, unstable;
    logic [7:0] od;
    repeat (3) @(posedge clock);
    #1 reset = 0;
    @(negedge clock);
    chk("reset_ctl", {49'd0, in_ready, out_valid, out_data, dbg_pc_ld, dbg_reg_ld, dbg_mem_read,
        dbg_mem_write, run}, {49'd0, 1'b1, 14'd0});
    chk("reset_dbg", {dbg_in, dbg_mem_addr}, 64'd0);
    chk("reset_reg_addr", {59'd0, dbg_reg_addr}, 64'd0);

    base = n_pc;
    sb.push_back(8'hAA);
    send_byte(8'h01);
    send4(32'h1000_0000);
    wait_drain("wpc_drain");
    chk("wpc_pulses", n_pc - base, 1);
    chk("wpc_dbg_in", stb_in, 32'h1000_0000);
    chk("wpc_dbg_in_pre", stb_pre, 32'h1000_0000);
    chk("wpc_dbg_in_post", stb_post, 32'h1000_0000);
    chk("wpc_strobe_lat", stb_cyc - acc_cyc, 2);
    chk("wpc_ack_lat", ov_cyc - acc_cyc, 5);

    base = n_mw;
    base2 = n_mr;
    sb.push_back(8'hAA);
    send_byte(8'h02);
    send4(32'h1000_0004);
    send4(32'hDEAD_BEEF);
    wait_drain("wmem_drain");
    chk("wmem_pulses", n_mw - base, 1);
    chk("wmem_addr", dbg_mem_addr, 32'h1000_0004);
    expect4(32'hDEAD_BEEF);
    send_byte(8'h03);
    send4(32'h1000_0004);
    wait_drain("rmem_drain");
    chk("rmem_pulses", n_mr - base2, 1);
    chk("rmem_ack_lat", ov_cyc - acc_cyc, 5);

    base = n_reg;
    sb.push_back(8'hAA);
    send_byte(8'h04);
    send_byte(8'h0A);
    send4(32'h0000_002A);
    wait_drain("wreg_drain");
    chk("wreg_pulses", n_reg - base, 1);
    chk("wreg_addr", {59'd0, dbg_reg_addr}, 64'd10);
    expect4(32'h0000_002A);
    send_byte(8'h05);
    send_byte(8'h0A);
    wait_drain("rreg_drain");
    expect4(32'h0000_002A);
    send_byte(8'h05);
    send_byte(8'hEA);
    wait_drain("rreg_hi_drain");
    chk("rreg_hi_addr", {59'd0, dbg_reg_addr}, 64'd10);

    base = n_run;
    sb.push_back(8'hAA);
    send_byte(8'h06);
    r_acc = acc_cyc;
    running = 1;
    expect4(32'h1000_0000);
    send_byte(8'h07);
    r_ov = ov_cyc;
    pops = n_pop;
    repeat (15) @(negedge clock);
    chk("rpc_stall_pops", n_pop - pops, 0);
    chk("rpc_stall_ov", {63'd0, out_valid}, 0);
    running = 0;
    wait_drain("rpc_drain");
    chk("run_cycles", n_run - base, 2);
    chk("run_rise", run_cyc - r_acc, 1);
    chk("run_ack_lat", r_ov - r_acc, 3);

    base = n_pc + n_reg + n_mr + n_mw + n_run;
    sb.push_back(8'hEE);
    send_byte(8'h55);
    wait_drain("bad_op_drain");
    chk("bad_op_strobes", n_pc + n_reg + n_mr + n_mw + n_run - base, 0);
    base = n_pc;
    sb.push_back(8'hAA);
    send_byte(8'h01);
    send4(32'h0000_0008);
    wait_drain("wpc2_drain");
    chk("wpc2_pulses", n_pc - base, 1);
    chk("wpc2_dbg_in", stb_in, 32'h0000_0008);

    out_ready = 0;
    expect4(32'hDEAD_BEEF);
    send_byte(8'h03);
    send4(32'h1000_0004);
    for (int i = 0; i < 50 && !out_valid; i++) @(negedge clock);
    chk("hold_ov_seen", {63'd0, out_valid}, 1);
    od = out_data;
    unstable = 0;
    repeat (10) begin
      @(negedge clock);
      if (!out_valid || out_data !== od) unstable++;
    end
    chk("hold_stable", unstable, 0);
    chk("hold_no_pop", sb.size(), 4);
    @(posedge clock);
    #1 out_ready = 1;
    wait_drain("hold_drain");

    base = n_mw;
    send_byte(8'h02);
    send_byte(8'h20);
    send_byte(8'h00);
    send_byte(8'h00);
    reset = 1;
    @(posedge clock);
    #1 reset = 0;
    @(negedge clock);
    chk("rst_in_ready", {63'd0, in_ready}, 1);
    chk("rst_out_valid", {63'd0, out_valid}, 0);
    expect4(32'h0000_0008);
    send_byte(8'h07);
    wait_drain("rst_rpc_drain");
    chk("rst_no_write", n_mw - base, 0);

    repeat (3) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/kappa3_dbg_loader.md
# kappa3_dbg_loader

Byte-stream command sequencer that drives the debug port of `kappa3_light_core` from a host link (UART receiver/transmitter or testbench byte driver). It sits directly upstream of the core's debug inputs. It converts framed commands into correctly timed `dbg_*` setup/strobe/settle sequences: load PC, write/read memory, write/read register, start run. Read data and acknowledges return on an output byte stream.

## Interface
- `SETTLE_CYCLES`, 2 — cycles after strobe deassert before capture/ack.
- `RUN_PULSE`, 2 — cycles `run` is held high.
- `clock`  in  1  — system clock.
- `reset`  in  1  — synchronous, active-high.
- `in_data`  in  8  — command/argument byte.
- `in_valid`  in  1  — `in_data` valid.
- `in_ready`  out  1  — byte accepted when `in_valid & in_ready`.
- `out_data`  out  8  — response byte.
- `out_valid`  out  1  — response byte valid.
- `out_ready`  in  1  — host accepts response byte.
- `running`  in  1  — core running flag.
- `dbg_pc_out`, `dbg_reg_out`, `dbg_mem_out`  in  32 each — core debug read-back.
- `dbg_in`  out  32 — data to core.
- `dbg_mem_addr`  out  32 — memory address.
- `dbg_reg_addr`  out  5 — register index.
- `dbg_pc_ld`, `dbg_reg_ld`, `dbg_mem_read`, `dbg_mem_write`, `run`  out  1 each — one-hot strobes. The core's `dbg_ir_ld`, `dbg_a_ld`, `dbg_b_ld` and `dbg_c_ld` are tied low at top level.

## Operation
- Opcodes; arguments are big-endian:
  - 0x01 WPC: data[4].
  - 0x02 WMEM: addr[4], data[4].
  - 0x03 RMEM: addr[4].
  - 0x04 WREG: idx[1], low 5 bits used.
  - 0x05 RREG: idx[1].
  - 0x06 RUN.
  - 0x07 RPC.
- WREG is followed by data[4].
- Responses:
  - Write commands return 0xAA.
  - Read commands return 4 bytes, MSB first.
  - RUN returns 0xAA after the pulse ends.
  - Unknown opcode returns 0xEE; no strobe; back to IDLE.
- FSM states:
  - IDLE: accept opcode. Decode argument count 0/1/4/5/8; zero args → WAIT_HALT.
  - ARG: shift bytes into an addr/data/idx shift register; byte counter counts down; last byte → WAIT_HALT.
  - WAIT_HALT: stay while `running`=1. Otherwise → SETUP, or → RUNP for RUN.
  - SETUP: `dbg_in`/`dbg_mem_addr`/`dbg_reg_addr` driven, all strobes low; 1 cycle.
  - STROBE: selected strobe high exactly 1 cycle. No strobe for RREG/RPC.
  - SETTLE: `SETTLE_CYCLES` cycles. Last cycle registers the read-back source (mem/reg/pc) into the response buffer.
  - RUNP: `run` high `RUN_PULSE` cycles; ignores `running`.
  - RESP: serialize 1 or 4 bytes; advance on `out_valid & out_ready`; last byte accepted → IDLE.
- `in_ready` = 1 only in IDLE and ARG. Bytes are never dropped or duplicated.
- Only one command is in flight; no pipelining of commands.

## Timing
- Reset values: all strobes 0, `run` 0, `dbg_in`/`dbg_mem_addr` 0, `dbg_reg_addr` 0, `out_valid` 0, `out_data` 0, FSM IDLE. `in_ready` is 1 the first cycle after reset deasserts.
- All outputs are registered except `in_ready`, which decodes the state.
- `dbg_in`, `dbg_mem_addr` and `dbg_reg_addr` are held stable from SETUP through end of SETTLE, and hold their values in IDLE.
- Latency, last arg byte accepted at cycle N with `running`=0:
  - SETUP at N+1.
  - Strobe at N+2.
  - Capture at N+2+`SETTLE_CYCLES`.
  - `out_valid` at N+3+`SETTLE_CYCLES`.
  - With defaults: strobe N+2, `out_valid` N+5.
- RUN: `run` high cycles N+1..N+`RUN_PULSE`; 0xAA valid at N+`RUN_PULSE`+1.
- `out_data` holds and `out_valid` stays high while `out_ready`=0.
- `reset` mid-command (any state): partial arguments discarded, any strobe/`run` drops the next cycle, pending response bytes dropped, FSM returns to IDLE.
- `in_valid` while not ready is ignored; the host must hold the byte.
- `running` rising during SETUP/STROBE/SETTLE does not abort the sequence.

## Test plan
- Reset then WPC 01 10 00 00 00 → `dbg_pc_ld` high exactly 1 cycle with `dbg_in`=0x10000000 stable the cycle before and after; response 0xAA.
- WMEM 02 10 00 00 04 DE AD BE EF, then RMEM 03 10 00 00 04 → one `dbg_mem_write` pulse, then one `dbg_mem_read` pulse; response DE AD BE EF.
- WREG 04 0A 00 00 00 2A, then RREG 05 0A → `dbg_reg_addr`=10, one `dbg_reg_ld`; response 00 00 00 2A. RREG 05 EA → index 10, same data.
- RUN 06 with `running` then held 1; send RPC 07 → `run` high 2 cycles, ack 0xAA; RPC stalls in WAIT_HALT until `running`=0, then returns `dbg_pc_out`.
- Opcode 0x55 → response 0xEE, no strobe; next WPC works. `out_ready` held low 10 cycles during RMEM → `out_data`/`out_valid` stable, no byte lost.
- Assert `reset` after 3 of 8 WMEM argument bytes → no `dbg_mem_write` pulse, no response, `in_ready`=1 next cycle, new command decodes from IDLE.
